// File: rtl/lab3_cache_xfer_pkg.sv
// Shared types and constants for the cache line transfer engine.
package lab3_cache_xfer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SPILL  = 2'd1,
      REFILL = 2'd2
   } xfer_state_e;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   // Ceiling log2; callers guarantee n >= 2 so the result is never zero.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cache_xfer_idx_ctr.sv
// Loadable wrapping word-index counter with a companion count of steps taken since load.
module cache_xfer_idx_ctr
   import lab3_cache_xfer_pkg::*;
#(
   parameter int unsigned WORDS = 4,
   localparam int unsigned IDX_W = clog2(WORDS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [IDX_W-1:0] load_idx_i,
   input  logic             inc_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o,
   output logic             done_o
);

   localparam logic [IDX_W:0] CntLast = (IDX_W + 1)'(WORDS - 1);
   localparam logic [IDX_W:0] CntFull = (IDX_W + 1)'(WORDS);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W:0]   cnt_q, cnt_d;

   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (load_i) begin
         idx_d = load_idx_i;
         cnt_d = '0;
      end else if (inc_i) begin
         idx_d = idx_q + 1'b1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = (cnt_q == CntLast);
   assign done_o = (cnt_q == CntFull);

endmodule

// File: rtl/cache_line_xfer_unit.sv
// Spill/refill line transfer engine between the cache controller and memory.
// Optional CACHE_XFER_CRIT_WORD_FIRST_EN: refill reads start at cmd_crit_idx_i and wrap.
module cache_line_xfer_unit
   import lab3_cache_xfer_pkg::*;
#(
   parameter int unsigned WORDS   = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_OUT = 2,
   localparam int unsigned IDX_W  = clog2(WORDS)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cmd_val_i,
   output logic                    cmd_rdy_o,
   input  logic                    cmd_spill_i,
   input  logic                    cmd_refill_i,
   input  logic [ADDR_W-1:0]       cmd_spill_addr_i,
   input  logic [ADDR_W-1:0]       cmd_refill_addr_i,
   input  logic [IDX_W-1:0]        cmd_crit_idx_i,
   input  logic [WORDS*DATA_W-1:0] cmd_spill_line_i,
   output logic                    cache_req_val_o,
   input  logic                    cache_req_rdy_i,
   output logic                    cache_req_type_o,
   output logic [ADDR_W-1:0]       cache_req_addr_o,
   output logic [DATA_W-1:0]       cache_req_data_o,
   input  logic                    cache_resp_val_i,
   output logic                    cache_resp_rdy_o,
   input  logic                    cache_resp_type_i,
   input  logic [DATA_W-1:0]       cache_resp_data_i,
   output logic                    spill_done_o,
   output logic                    refill_req_done_o,
   output logic                    refill_resp_done_o,
   output logic [WORDS*DATA_W-1:0] refill_line_o
);

   localparam int unsigned BASE_W = ADDR_W - IDX_W - 2;
   localparam int unsigned OUT_W  = clog2(MAX_OUT + 1);
   localparam logic [OUT_W-1:0] OutMax = OUT_W'(MAX_OUT);

   xfer_state_e             state_q, state_d;
   logic [BASE_W-1:0]       spill_base_q, refill_base_q;
   logic [WORDS*DATA_W-1:0] spill_line_q;
   logic [WORDS*DATA_W-1:0] refill_line_q, refill_line_d;
   logic                    cmd_refill_q;
   logic [IDX_W-1:0]        refill_start_q, refill_start_in;
   logic [OUT_W-1:0]        out_q, out_d;
   logic                    spill_done_q, spill_done_d;
   logic                    req_done_q, req_done_d;
   logic                    resp_done_q, resp_done_d;

   logic                    cmd_accept, in_spill, req_val, req_fire, resp_rdy, resp_fire;
   logic                    ctr_load;
   logic [IDX_W-1:0]        ctr_load_idx;
   logic [IDX_W-1:0]        req_idx, resp_idx;
   logic                    req_last, req_all, resp_last, resp_all;

`ifdef CACHE_XFER_CRIT_WORD_FIRST_EN
   assign refill_start_in = cmd_crit_idx_i;
   logic unused_crit;
   assign unused_crit = 1'b0;
`else
   assign refill_start_in = '0;
   logic unused_crit;
   assign unused_crit = ^cmd_crit_idx_i;
`endif

   logic unused_bits;
   assign unused_bits = ^{cmd_spill_addr_i[IDX_W+1:0], cmd_refill_addr_i[IDX_W+1:0], resp_all,
                          unused_crit};

   cache_xfer_idx_ctr #(
      .WORDS (WORDS)
   ) u_req_ctr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (ctr_load),
      .load_idx_i (ctr_load_idx),
      .inc_i      (req_fire),
      .idx_o      (req_idx),
      .last_o     (req_last),
      .done_o     (req_all)
   );

   cache_xfer_idx_ctr #(
      .WORDS (WORDS)
   ) u_resp_ctr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (ctr_load),
      .load_idx_i (ctr_load_idx),
      .inc_i      (resp_fire),
      .idx_o      (resp_idx),
      .last_o     (resp_last),
      .done_o     ()
   );
   assign resp_all = 1'b0;

   assign cmd_rdy_o  = (state_q == IDLE);
   assign cmd_accept = cmd_rdy_o && cmd_val_i;
   assign in_spill   = (state_q == SPILL);
   assign req_val    = (state_q != IDLE) && !req_all && (out_q < OutMax);
   assign req_fire   = req_val && cache_req_rdy_i;
   assign resp_rdy   = (out_q != '0);
   assign resp_fire  = resp_rdy && cache_resp_val_i;

   assign cache_req_val_o  = req_val;
   assign cache_req_type_o = in_spill ? MEM_WR : MEM_RD;
   assign cache_req_addr_o = {(in_spill ? spill_base_q : refill_base_q), req_idx, 2'b00};
   assign cache_req_data_o = in_spill ? spill_line_q[DATA_W*req_idx +: DATA_W] : '0;
   assign cache_resp_rdy_o = resp_rdy;

   always_comb begin
      out_d = out_q;
      case ({req_fire, resp_fire})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: out_d = out_q;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      spill_done_d  = 1'b0;
      resp_done_d   = 1'b0;
      req_done_d    = req_done_q;
      refill_line_d = refill_line_q;
      ctr_load      = 1'b0;
      ctr_load_idx  = '0;
      unique case (state_q)
         IDLE: begin
            req_done_d = 1'b0;
            if (cmd_val_i && cmd_spill_i) begin
               state_d  = SPILL;
               ctr_load = 1'b1;
            end else if (cmd_val_i && cmd_refill_i) begin
               state_d      = REFILL;
               ctr_load     = 1'b1;
               ctr_load_idx = refill_start_in;
            end
         end
         SPILL: begin
            // Reads only start once the final write ack has been taken.
            if (resp_fire && resp_last) begin
               spill_done_d = 1'b1;
               if (cmd_refill_q) begin
                  state_d      = REFILL;
                  ctr_load     = 1'b1;
                  ctr_load_idx = refill_start_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         REFILL: begin
            if (req_fire && req_last) begin
               req_done_d = 1'b1;
            end
            if (resp_fire && (cache_resp_type_i == MEM_RD)) begin
               refill_line_d[DATA_W*resp_idx +: DATA_W] = cache_resp_data_i;
            end
            if (resp_fire && resp_last) begin
               state_d     = IDLE;
               resp_done_d = 1'b1;
               req_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         spill_base_q   <= '0;
         refill_base_q  <= '0;
         spill_line_q   <= '0;
         cmd_refill_q   <= 1'b0;
         refill_start_q <= '0;
         refill_line_q  <= '0;
         out_q          <= '0;
         spill_done_q   <= 1'b0;
         req_done_q     <= 1'b0;
         resp_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         refill_line_q <= refill_line_d;
         out_q         <= out_d;
         spill_done_q  <= spill_done_d;
         req_done_q    <= req_done_d;
         resp_done_q   <= resp_done_d;
         if (cmd_accept) begin
            spill_base_q   <= cmd_spill_addr_i[ADDR_W-1:IDX_W+2];
            refill_base_q  <= cmd_refill_addr_i[ADDR_W-1:IDX_W+2];
            spill_line_q   <= cmd_spill_line_i;
            cmd_refill_q   <= cmd_refill_i;
            refill_start_q <= refill_start_in;
         end
      end
   end

   assign spill_done_o       = spill_done_q;
   assign refill_req_done_o  = req_done_q;
   assign refill_resp_done_o = resp_done_q;
   assign refill_line_o      = refill_line_q;

endmodule

// File: tb/tb_cache_line_xfer_unit.sv
// Directed self-checking bench for cache_line_xfer_unit with a latency-programmable memory model.
module tb_cache_line_xfer_unit;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_val = 1'b0, cmd_spill = 1'b0, cmd_refill = 1'b0;
   logic [31:0]  cmd_spill_addr = '0, cmd_refill_addr = '0;
   logic [1:0]   cmd_crit = '0;
   logic [127:0] cmd_line = '0;
   logic         cmd_rdy;
   logic         req_val, req_rdy = 1'b1, req_type;
   logic [31:0]  req_addr, req_data;
   logic         resp_val = 1'b0, resp_rdy, resp_type = 1'b0;
   logic [31:0]  resp_data = '0;
   logic         spill_done, req_done, resp_done;
   logic [127:0] refill_line;

   localparam logic [127:0] ExpLine = 128'h000000A3_000000A2_000000A1_000000A0;

   always #5 clk = ~clk;

   cache_line_xfer_unit dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .cmd_val_i          (cmd_val),
      .cmd_rdy_o          (cmd_rdy),
      .cmd_spill_i        (cmd_spill),
      .cmd_refill_i       (cmd_refill),
      .cmd_spill_addr_i   (cmd_spill_addr),
      .cmd_refill_addr_i  (cmd_refill_addr),
      .cmd_crit_idx_i     (cmd_crit),
      .cmd_spill_line_i   (cmd_line),
      .cache_req_val_o    (req_val),
      .cache_req_rdy_i    (req_rdy),
      .cache_req_type_o   (req_type),
      .cache_req_addr_o   (req_addr),
      .cache_req_data_o   (req_data),
      .cache_resp_val_i   (resp_val),
      .cache_resp_rdy_o   (resp_rdy),
      .cache_resp_type_i  (resp_type),
      .cache_resp_data_i  (resp_data),
      .spill_done_o       (spill_done),
      .refill_req_done_o  (req_done),
      .refill_resp_done_o (resp_done),
      .refill_line_o      (refill_line)
   );

   int n_cmp = 0, n_err = 0;
   int cyc = 0, lat = 1;
   bit toggle = 1'b0;

   logic [31:0] log_addr [64];
   logic [31:0] log_data [64];
   logic        log_type [64];
   int          log_wracks [64];
   int          log_n = 0;
   int          wr_acks = 0, n_spill_done = 0, n_resp_done = 0, n_rqd_cycles = 0;
   int          tb_out = 0, max_out = 0;
   logic [127:0] line_at_done = '0;

   int          pq_ready [$];
   logic        pq_type [$];
   logic [31:0] pq_data [$];
   logic        prev_stall = 1'b0, prev_type = 1'b0;
   logic [31:0] prev_addr = '0, prev_data = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Memory model and monitor: inputs change on the falling edge, fires are judged from the
   // values the DUT will sample at the following rising edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pq_ready.delete();
         pq_type.delete();
         pq_data.delete();
         resp_val   = 1'b0;
         req_rdy    = 1'b1;
         tb_out     = 0;
         prev_stall = 1'b0;
      end else begin
         req_rdy = toggle ? ~req_rdy : 1'b1;
         if (pq_ready.size() > 0 && cyc >= pq_ready[0]) begin
            resp_val  = 1'b1;
            resp_type = pq_type[0];
            resp_data = pq_data[0];
         end else begin
            resp_val = 1'b0;
         end
         if (prev_stall) begin
            check("req_stable", {req_val, req_type, req_addr, req_data},
                  {1'b1, prev_type, prev_addr, prev_data});
         end
         if (req_val && req_rdy) begin
            if (log_n < 64) begin
               log_addr[log_n]   = req_addr;
               log_data[log_n]   = req_data;
               log_type[log_n]   = req_type;
               log_wracks[log_n] = wr_acks;
               log_n++;
            end
            pq_ready.push_back(cyc + lat);
            pq_type.push_back(req_type);
            pq_data.push_back(req_type ? 32'h0 : 32'hA0 + 32'(req_addr[3:2]));
            tb_out++;
         end
         if (resp_val && resp_rdy) begin
            if (pq_type[0]) wr_acks++;
            void'(pq_ready.pop_front());
            void'(pq_type.pop_front());
            void'(pq_data.pop_front());
            tb_out--;
         end
         if (tb_out > max_out) max_out = tb_out;
         prev_stall = req_val && !req_rdy;
         prev_type  = req_type;
         prev_addr  = req_addr;
         prev_data  = req_data;
         if (spill_done) n_spill_done++;
         if (req_done) n_rqd_cycles++;
         if (resp_done) begin
            n_resp_done++;
            line_at_done = refill_line;
         end
      end
   end

   task automatic send(input logic sp, input logic rf, input logic [31:0] sa, input logic [31:0] ra,
                       input logic [1:0] crit, input logic [127:0] line);
      cmd_spill       = sp;
      cmd_refill      = rf;
      cmd_spill_addr  = sa;
      cmd_refill_addr = ra;
      cmd_crit        = crit;
      cmd_line        = line;
      cmd_val         = 1'b1;
      @(negedge clk);
      cmd_val    = 1'b0;
      cmd_spill  = 1'b0;
      cmd_refill = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (cmd_rdy) break;
      end
      check(tag, 128'(cmd_rdy), 128'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int b, sd, rd, wa, rq;
      logic [31:0] exp6 [4];

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_rdy", 128'(cmd_rdy), 128'd1);
      check("rst_req_val", 128'(req_val), 128'd0);
      check("rst_resp_rdy", 128'(resp_rdy), 128'd0);
      check("rst_done", 128'({spill_done, req_done, resp_done}), 128'd0);
      check("rst_line", refill_line, 128'd0);

      // No-op command
      b = log_n;
      send(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 128'd0);
      check("noop_rdy", 128'(cmd_rdy), 128'd1);
      repeat (3) @(negedge clk);
      check("noop_nreq", 128'(log_n - b), 128'd0);

      // 1: spill only
      b = log_n; sd = n_spill_done; rd = n_resp_done;
      send(1'b1, 1'b0, 32'h1000, 32'h0, 2'd0, {32'd4, 32'd3, 32'd2, 32'd1});
      check("t1_first_val", 128'({req_val, cmd_rdy}), 128'b10);
      wait_idle("t1_idle");
      check("t1_nreq", 128'(log_n - b), 128'd4);
      for (int i = 0; i < 4; i++) begin
         check("t1_wr", {log_type[b+i], log_addr[b+i], log_data[b+i]},
               {1'b1, 32'(32'h1000 + 4 * i), 32'(i + 1)});
      end
      check("t1_spill_done", 128'(n_spill_done - sd), 128'd1);
      check("t1_no_resp_done", 128'(n_resp_done - rd), 128'd0);

      // 2: refill only
      b = log_n; rd = n_resp_done; rq = n_rqd_cycles;
      send(1'b0, 1'b1, 32'h0, 32'h2000, 2'd0, 128'd0);
      check("t2_first_val", 128'(req_val), 128'd1);
      wait_idle("t2_idle");
      check("t2_nreq", 128'(log_n - b), 128'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_rd", {log_type[b+i], log_addr[b+i]}, {1'b0, 32'(32'h2000 + 4 * i)});
      end
      check("t2_line", refill_line, ExpLine);
      check("t2_line_at_done", line_at_done, ExpLine);
      check("t2_resp_done", 128'(n_resp_done - rd), 128'd1);
      check("t2_req_done_seen", 128'(n_rqd_cycles > rq), 128'd1);
      check("t2_req_done_clr", 128'(req_done), 128'd0);

      // 3: spill then refill
      b = log_n; sd = n_spill_done; rd = n_resp_done; wa = wr_acks;
      send(1'b1, 1'b1, 32'h3000, 32'h2000, 2'd0, {32'h44, 32'h33, 32'h22, 32'h11});
      wait_idle("t3_idle");
      check("t3_nreq", 128'(log_n - b), 128'd8);
      for (int i = 0; i < 4; i++) begin
         check("t3_wr", {log_type[b+i], log_addr[b+i], log_data[b+i]},
               {1'b1, 32'(32'h3000 + 4 * i), 32'(32'h11 * (i + 1))});
         check("t3_rd", {log_type[b+4+i], log_addr[b+4+i]}, {1'b0, 32'(32'h2000 + 4 * i)});
      end
      check("t3_rd_after_acks", 128'(log_wracks[b+4] - wa), 128'd4);
      check("t3_spill_done", 128'(n_spill_done - sd), 128'd1);
      check("t3_resp_done", 128'(n_resp_done - rd), 128'd1);
      check("t3_line", refill_line, ExpLine);

      // 4: backpressure with 3-cycle memory
      lat = 3; toggle = 1'b1;
      b = log_n;
      send(1'b0, 1'b1, 32'h0, 32'h2000, 2'd0, 128'd0);
      wait_idle("t4_idle");
      toggle = 1'b0;
      check("t4_nreq", 128'(log_n - b), 128'd4);
      for (int i = 0; i < 4; i++) begin
         check("t4_rd", {log_type[b+i], log_addr[b+i]}, {1'b0, 32'(32'h2000 + 4 * i)});
      end
      check("t4_max_out", 128'(max_out <= 2), 128'd1);
      check("t4_line", refill_line, ExpLine);

      // 5: reset after two reads issued
      lat = 3;
      b = log_n; sd = n_spill_done; rd = n_resp_done;
      send(1'b0, 1'b1, 32'h0, 32'h2000, 2'd0, 128'd0);
      for (int k = 0; k < 50; k++) begin
         if (log_n - b >= 2) break;
         @(negedge clk);
      end
      check("t5_two_reads", 128'(log_n - b), 128'd2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_state", 128'({cmd_rdy, req_val, resp_rdy, req_done}), 128'b1000);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t5_no_more_req", 128'(log_n - b), 128'd2);
      check("t5_no_pulses", 128'({n_spill_done - sd, n_resp_done - rd}), 128'd0);
      check("t5_line_cleared", refill_line, 128'd0);
      lat = 1;
      rd = n_resp_done;
      send(1'b0, 1'b1, 32'h0, 32'h2000, 2'd0, 128'd0);
      wait_idle("t5_idle");
      check("t5_line", refill_line, ExpLine);
      check("t5_resp_done", 128'(n_resp_done - rd), 128'd1);

      // 6: critical word index 2
`ifdef CACHE_XFER_CRIT_WORD_FIRST_EN
      exp6[0] = 32'h2008; exp6[1] = 32'h200C; exp6[2] = 32'h2000; exp6[3] = 32'h2004;
`else
      exp6[0] = 32'h2000; exp6[1] = 32'h2004; exp6[2] = 32'h2008; exp6[3] = 32'h200C;
`endif
      b = log_n;
      send(1'b0, 1'b1, 32'h0, 32'h2000, 2'd2, 128'd0);
      wait_idle("t6_idle");
      check("t6_nreq", 128'(log_n - b), 128'd4);
      for (int i = 0; i < 4; i++) begin
         check("t6_rd", {log_type[b+i], log_addr[b+i]}, {1'b0, exp6[i]});
      end
      check("t6_line", refill_line, ExpLine);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
